mux_nto1_stream: RTL
====================

// Module: mux_nto1_stream
// PURPOSE
//   N-channel, W-bit registered multiplexer with valid/ready handshake.
//   Generalises the 4:1 single-bit muxes to any channel count and data width.
//   Adds a runtime mode: external select, or round-robin over valid channels.
//   Sits between N producer streams and one consumer; holds one output beat.
// PARAMETERS
//   N      4   number of input channels (>=2)
//   W      8   data width per channel
//   SELW   $clog2(N)   localparam, width of sel / out_ch
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   mode       in   1       0 = SEL mode (use sel), 1 = RR mode (round-robin)
//   sel        in   SELW    channel index, used in SEL mode only
//   in_data    in   N*W     channel k at bits [k*W +: W]
//   in_valid   in   N       per-channel valid
//   in_ready   out  N       per-channel ready, one-hot or zero
//   out_data   out  W       registered selected data
//   out_ch     out  SELW    channel index of the held beat
//   out_valid  out  1       output register holds a beat
//   out_ready  in   1       consumer accepts the beat
// BEHAVIOUR
//   - Reset (async, immediate): out_valid=0, out_data=0, out_ch=0,
//     last-grant pointer ptr=N-1 (channel 0 is first RR priority), FSM=EMPTY.
//   - FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//     load = (state==EMPTY) | (out_valid & out_ready).
//     EMPTY->FULL on load with a grant; FULL->EMPTY on drain without a grant;
//     FULL->FULL on drain+grant (back-to-back, one beat per cycle sustained).
//   - Grant, combinational, evaluated only when load=1:
//     SEL: grant channel sel iff sel<N and in_valid[sel]; else no grant.
//     RR : first valid channel scanning ptr+1, ptr+2, ... mod N; else no grant.
//   - in_ready[g]=1 only for the granted channel g in a load cycle; all 0 else.
//     Transfer on a channel = in_valid[k] & in_ready[k].
//   - On grant: next edge out_data<=in_data[g], out_ch<=g, out_valid<=1,
//     ptr<=g (ptr updates in both modes). Latency: input to output = 1 cycle.
//   - Held beat is stable (data, ch) while out_valid & !out_ready.
//   - mode/sel changes affect only the next grant, never the held beat.
//   - sel>=N (N not power of 2): no grant, no stall of held data.
//   - RR wrap: ptr=N-1 scans from channel 0. Single valid channel is granted
//     every load cycle (no forced idle).
//   - rst mid-transfer: held beat is discarded; no in_ready until rst falls.
// STRUCTURE
//   - Shared package mux_pkg: MODE_SEL=1'b0, MODE_RR=1'b1, state encoding
//     ST_EMPTY/ST_FULL.
//   - Sub-module rr_pick #(N): in req[N], ptr[SELW]; out gnt_vld, gnt_idx.
//     Pure combinational rotate-priority; top holds FSM, ptr, output register.
// TESTING  (N=4, W=8)
//   1 Reset: assert rst mid-run with out_valid=1 -> out_valid/out_data/out_ch
//     read 0 before next clk edge; in_ready=0000 while rst=1.
//   2 SEL mode, sel=2, in_valid=1111, in_data={8'h44,8'h33,8'h22,8'h11},
//     out_ready=1 -> in_ready=0100, next cycle out_data=8'h33, out_ch=2.
//   3 RR mode, all valid, out_ready=1 for 6 cycles -> out_ch 0,1,2,3,0,1;
//     one beat per cycle, no bubbles.
//   4 RR mode, in_valid=1010, ptr=1 -> grants 3 then 1 then 3; ch 0/2 never.
//   5 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and
//     out_ch constant, in_ready=0000; raise out_ready -> new beat next cycle.
//   6 Mode switch SEL->RR while FULL and stalled -> held beat unchanged;
//     next grant follows RR from ptr of last grant.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the N:1 stream multiplexer: runtime mode and output FSM encoding.
package mux_pkg;
  localparam logic       MODE_SEL = 1'b0;
  localparam logic       MODE_RR  = 1'b1;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/mux_nto1_stream_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr, wrapping mod N.
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);
  logic [SELW-1:0] w_c;

  // Scan from the farthest candidate (ptr+N) to the nearest (ptr+1); the last hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_c     = '0;
    for (int i = N; i >= 1; i--) begin
      w_c = SELW'((int'(ptr) + i) % N);
      if (req[w_c]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_c;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel W-bit registered stream mux; SEL or round-robin grant, one-beat output register.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:0]        dbg_state
);
  logic [0:0]      r_state;
  logic [SELW-1:0] r_ptr;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;

  logic            w_load;
  logic            w_rr_vld;
  logic [SELW-1:0] w_rr_idx;
  logic            w_sel_vld;
  logic            w_gnt_vld;
  logic [SELW-1:0] w_gnt_idx;
  logic [N-1:0]    w_in_ready;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_vld (w_rr_vld),
    .gnt_idx (w_rr_idx)
  );

  assign out_valid = (r_state == ST_FULL);
  assign w_load    = (r_state == ST_EMPTY) | (out_valid & out_ready);
  assign w_sel_vld = (int'(sel) < N) && in_valid[sel];

  // Grants are suppressed while rst is high so no producer sees ready during reset.
  assign w_gnt_vld = w_load & ~rst & ((mode == MODE_RR) ? w_rr_vld : w_sel_vld);
  assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : sel;

  always_comb begin
    w_in_ready = '0;
    if (w_gnt_vld) w_in_ready[w_gnt_idx] = 1'b1;
  end
  assign in_ready = w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= SELW'(N - 1);
      r_out_data <= '0;
      r_out_ch   <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_state    <= ST_FULL;
        r_ptr      <= w_gnt_idx;
        r_out_data <= in_data[w_gnt_idx*W +: W];
        r_out_ch   <= w_gnt_idx;
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign dbg_state = r_state;
endmodule
